// File: rtl/scan_chain_pkg.sv
// Shared scan-chain types: slot width, the per-cycle command and its decoder.
// Latency: none (types and a pure function only).
// Backpressure: none; the controller drives one command per cycle.
package scan_chain_pkg;

  localparam int SCAN_WIDTH = 8;

  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'd0,
    SCAN_SHIFT   = 2'd1,
    SCAN_CAPTURE = 2'd2
  } scan_cmd_t;

  function automatic scan_cmd_t decode_cmd(input logic shift_en, input logic scan_select);
    scan_cmd_t cmd;
    if (!shift_en)        cmd = SCAN_IDLE;
    else if (scan_select) cmd = SCAN_CAPTURE;
    else                  cmd = SCAN_SHIFT;
    return cmd;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Shift/capture register of one scan slot: serial shift MSB-out, or parallel load.
// Latency: 1 cycle per command; a serial bit reaches q[WIDTH-1] after WIDTH shifts.
// Backpressure: none; holds on SCAN_IDLE.
module scan_shift_reg
  import scan_chain_pkg::*;
#(
  parameter int WIDTH = SCAN_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  scan_cmd_t        cmd,
  input  logic             data_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (cmd)
        SCAN_SHIFT:   q <= {q[WIDTH-2:0], data_in};
        SCAN_CAPTURE: q <= par_in;
        default:      q <= q;
      endcase
    end
  end

endmodule

// File: rtl/scan_chain_slot.sv
// One daisy-chained scan slot: shift/capture register, latched design inputs, shift counter.
// Latency: WIDTH shifts through the slot (1 with SCAN_SLOT_BYPASS_EN and bypass=1); latch_done 1 cycle after latch_en.
// Backpressure: none; every command is acted on the cycle it is presented.
module scan_chain_slot
  import scan_chain_pkg::*;
#(
  parameter int WIDTH = SCAN_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             scan_select,
  input  logic             latch_en,
  input  logic             data_in,
  output logic             data_out,
  input  logic [WIDTH-1:0] module_data_out,
`ifdef SCAN_SLOT_BYPASS_EN
  input  logic             bypass,
`endif
  output logic [WIDTH-1:0] module_data_in,
  output logic             latch_done,
  output logic [CNT_W-1:0] shift_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  scan_cmd_t        cmd;
  scan_cmd_t        sr_cmd;
  logic             latch_fire;
  logic [WIDTH-1:0] sr;

  // In bypass the register, latch and counter are frozen; only the bypass flop moves.
  always_comb begin
    cmd        = decode_cmd(shift_en, scan_select);
    sr_cmd     = cmd;
    latch_fire = latch_en;
`ifdef SCAN_SLOT_BYPASS_EN
    if (bypass) begin
      sr_cmd     = SCAN_IDLE;
      latch_fire = 1'b0;
    end
`endif
  end

  scan_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk     (clk),
    .reset   (reset),
    .cmd     (sr_cmd),
    .data_in (data_in),
    .par_in  (module_data_out),
    .q       (sr)
  );

  // Latch samples sr before this edge's shift/capture; a clear beats the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      module_data_in <= '0;
      latch_done     <= 1'b0;
      shift_count    <= '0;
    end else begin
      latch_done <= latch_fire;
      if (latch_fire) begin
        module_data_in <= sr;
        shift_count    <= '0;
      end else if (sr_cmd == SCAN_SHIFT && shift_count != CNT_MAX) begin
        shift_count <= shift_count + CNT_W'(1);
      end
    end
  end

`ifdef SCAN_SLOT_BYPASS_EN
  logic byp_q;

  always_ff @(posedge clk) begin
    if (reset)                            byp_q <= 1'b0;
    else if (bypass && cmd == SCAN_SHIFT) byp_q <= data_in;
  end

  assign data_out = bypass ? byp_q : sr[WIDTH-1];
`else
  assign data_out = sr[WIDTH-1];
`endif

endmodule

// File: tb/tb_scan_chain_slot.sv
// Directed bench for scan_chain_slot: per-cycle vector table plus chained, reset and bypass sequences.
module tb_scan_chain_slot;

  logic       clk = 1'b0;
  logic       reset;
  logic       shift_en, scan_select, latch_en, data_in;
  logic [7:0] mdo0, mdo1;
  logic       do0, do1;
  logic [7:0] mdi0, mdi1;
  logic       ld0, ld1;
  logic [3:0] cnt0, cnt1;
`ifdef SCAN_SLOT_BYPASS_EN
  logic       bypass;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_chain_slot #(.WIDTH(8), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .scan_select(scan_select),
    .latch_en(latch_en), .data_in(data_in), .data_out(do0),
    .module_data_out(mdo0),
`ifdef SCAN_SLOT_BYPASS_EN
    .bypass(bypass),
`endif
    .module_data_in(mdi0), .latch_done(ld0), .shift_count(cnt0)
  );

  scan_chain_slot #(.WIDTH(8), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .scan_select(scan_select),
    .latch_en(latch_en), .data_in(do0), .data_out(do1),
    .module_data_out(mdo1),
`ifdef SCAN_SLOT_BYPASS_EN
    .bypass(1'b0),
`endif
    .module_data_in(mdi1), .latch_done(ld1), .shift_count(cnt1)
  );

  typedef struct {
    logic       se;
    logic       ss;
    logic       le;
    logic       di;
    logic [7:0] mdo;
    logic       exp_do;
    logic [7:0] exp_mdi;
    logic       exp_ld;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic se, input logic ss, input logic le, input logic di,
                     input logic [7:0] mdo, input logic e_do, input logic [7:0] e_mdi,
                     input logic e_ld, input logic [3:0] e_cnt);
    vec_t v;
    v.se = se; v.ss = ss; v.le = le; v.di = di; v.mdo = mdo;
    v.exp_do = e_do; v.exp_mdi = e_mdi; v.exp_ld = e_ld; v.exp_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic se, input logic ss, input logic le, input logic di);
    shift_en = se; scan_select = ss; latch_en = le; data_in = di;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] w;
    logic [7:0]  exp_hold;
    int          k;

    reset = 1'b1; mdo0 = 8'h00; mdo1 = 8'h00;
`ifdef SCAN_SLOT_BYPASS_EN
    bypass = 1'b0;
`endif
    drive(0, 0, 0, 0);
    tick(); tick();
    check("reset_do",  {7'd0, do0}, 8'h00);
    check("reset_mdi", mdi0, 8'h00);
    check("reset_ld",  {7'd0, ld0}, 8'h00);
    check("reset_cnt", {4'd0, cnt0}, 8'h00);
    reset = 1'b0;

    // Shift 0xA5 MSB-first, then latch and idle.
    b = 8'hA5;
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, b[7-i], 8'h00, (i == 7), 8'h00, 0, 4'(i + 1));
    add(0, 0, 1, 0, 8'h00, 1, 8'hA5, 1, 0);
    add(0, 0, 0, 0, 8'h00, 1, 8'hA5, 0, 0);
    // Capture 0x3C then serialise it out with zeros behind.
    b = 8'h3C;
    add(1, 1, 0, 0, b, b[7], 8'hA5, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 0, 0, 0, 8'h00, (i <= 7) ? b[7-i] : 1'b0, 8'hA5, 0, 4'(i));
    // sr=0x80, latch coincident with a shift of 1, then a back-to-back latch.
    add(1, 1, 0, 0, 8'h80, 1, 8'hA5, 0, 8);
    add(1, 0, 1, 1, 8'h00, 0, 8'h80, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h01, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0);
    // Saturating counter while shifting ones behind sr=0x01.
    for (int i = 1; i <= 18; i++)
      add(1, 0, 0, 1, 8'h00, (i >= 7), 8'h01, 0, (i > 15) ? 4'd15 : 4'(i));
    add(0, 0, 1, 0, 8'h00, 1, 8'hFF, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].se, vecs[i].ss, vecs[i].le, vecs[i].di);
      mdo0 = vecs[i].mdo;
      tick();
      check($sformatf("vec%0d_do", i),  {7'd0, do0}, {7'd0, vecs[i].exp_do});
      check($sformatf("vec%0d_mdi", i), mdi0, vecs[i].exp_mdi);
      check($sformatf("vec%0d_ld", i),  {7'd0, ld0}, {7'd0, vecs[i].exp_ld});
      check($sformatf("vec%0d_cnt", i), {4'd0, cnt0}, {4'd0, vecs[i].exp_cnt});
    end
    mdo0 = 8'h00;

    // Two chained slots: 0x12 then 0x34; inputs must not move while shifting.
    do_reset();
    w = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, w[15-i]);
      tick();
      check($sformatf("chain_hold0_%0d", i), mdi0, 8'h00);
      check($sformatf("chain_hold1_%0d", i), mdi1, 8'h00);
    end
    drive(0, 0, 1, 0);
    tick();
    check("chain_slot0", mdi0, 8'h34);
    check("chain_slot1", mdi1, 8'h12);
    check("chain_ld0", {7'd0, ld0}, 8'h01);
    check("chain_ld1", {7'd0, ld1}, 8'h01);
    drive(0, 0, 0, 0);
    tick();
    check("chain_ld0_pulse", {7'd0, ld0}, 8'h00);

    // Reset after 5 of 8 shifts discards everything; the next load works.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1);
      tick();
    end
    check("mid_cnt", {4'd0, cnt0}, 8'h05);
    reset = 1'b1;
    drive(1, 0, 1, 1);
    tick();
    reset = 1'b0;
    check("rst_mid_do",  {7'd0, do0}, 8'h00);
    check("rst_mid_mdi", mdi0, 8'h00);
    check("rst_mid_ld",  {7'd0, ld0}, 8'h00);
    check("rst_mid_cnt", {4'd0, cnt0}, 8'h00);
    b = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, b[7-i]);
      tick();
    end
    check("post_rst_cnt", {4'd0, cnt0}, 8'h08);
    check("post_rst_do",  {7'd0, do0}, 8'h00);
    drive(0, 0, 1, 0);
    tick();
    check("post_rst_mdi", mdi0, 8'h5A);
    check("post_rst_ld",  {7'd0, ld0}, 8'h01);
    check("post_rst_cnt0", {4'd0, cnt0}, 8'h00);

`ifdef SCAN_SLOT_BYPASS_EN
    // Bypass: one-cycle path through the slot; register, latch and count frozen.
    bypass = 1'b1;
    b = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) begin
      drive(1, 0, 0, b[i]);
      tick();
      check($sformatf("byp_do_%0d", i), {7'd0, do0}, {7'd0, b[i]});
    end
    mdo0 = 8'hC3;
    drive(1, 1, 1, 0);
    tick();
    check("byp_cap_do", {7'd0, do0}, 8'h01);
    check("byp_ld", {7'd0, ld0}, 8'h00);
    check("byp_cnt", {4'd0, cnt0}, 8'h00);
    check("byp_mdi", mdi0, 8'h5A);
    bypass = 1'b0;
    mdo0 = 8'h00;
    drive(0, 0, 1, 0);
    tick();
    check("byp_off_mdi", mdi0, 8'h5A);
    check("byp_off_do", {7'd0, do0}, 8'h00);
`endif

    k = 0;
    exp_hold = mdi0;
    drive(0, 0, 0, 0);
    tick();
    check("final_idle_mdi", mdi0, exp_hold);
    k++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
